// File: rtl/dcm_prog_responder_if.sv
// Serial programming link between a DCM_PROG master and dcm_prog_responder.
// The master drives the frame enable/data; the responder reports readiness on done.
interface dcm_prog_responder_if;
  logic dcm_prog_en;
  logic dcm_prog_data;
  logic dcm_prog_done;

  modport master (
    output dcm_prog_en,
    output dcm_prog_data,
    input  dcm_prog_done
  );

  modport slave (
    input  dcm_prog_en,
    input  dcm_prog_data,
    output dcm_prog_done
  );
endinterface

// File: rtl/dcm_prog_responder.sv
// Responder model of a DCM dynamic programming port.
// Captures serial frames (LoadD, LoadM, GO), keeps pending M/D values, applies
// them on GO and holds dcm_prog_done low for DONE_LATENCY cycles afterwards.
// Malformed frames, out-of-range multipliers and frames ending while settling
// are rejected and counted in a saturating error counter.
module dcm_prog_responder #(
  parameter int unsigned INITIAL_MULTIPLIER = 60,
  parameter int unsigned INITIAL_DIVIDER    = 8,
  parameter int unsigned MAXIMUM_MULTIPLIER = 88,
  parameter int unsigned DONE_LATENCY       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  dcm_prog_responder_if.slave   prog,
  output logic [7:0]            multiplier,
  output logic [7:0]            divider,
  output logic                  load_strobe,
  output logic                  frame_error,
  output logic [7:0]            error_count
);

  localparam logic [7:0] INIT_MUL_C   = 8'(INITIAL_MULTIPLIER);
  localparam logic [7:0] INIT_DIV_C   = 8'(INITIAL_DIVIDER);
  localparam logic [7:0] INIT_PMUL_C  = 8'(INITIAL_MULTIPLIER - 1);
  localparam logic [7:0] INIT_PDIV_C  = 8'(INITIAL_DIVIDER - 1);
  localparam logic [7:0] LATENCY_C    = 8'(DONE_LATENCY);
  localparam logic [8:0] MAX_MUL_C    = 9'(MAXIMUM_MULTIPLIER);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_CAPTURE = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;     // saturates at 11 (= "more than 10")
  logic [9:0]  shift_q, shift_d;         // bit i of the frame lands in shift[i]
  logic [7:0]  pend_mul_q, pend_mul_d;   // pending fields (value - 1)
  logic [7:0]  pend_div_q, pend_div_d;
  logic [7:0]  mul_q, mul_d;             // active values
  logic [7:0]  div_q, div_d;
  logic [7:0]  settle_q, settle_d;
  logic        done_q, done_d;
  logic        strobe_q, strobe_d;
  logic        ferr_q, ferr_d;
  logic [7:0]  errcnt_q, errcnt_d;

  logic [7:0]  field_s;
  logic [8:0]  m_plus_s;

  assign field_s  = shift_q[9:2];
  assign m_plus_s = {1'b0, field_s} + 9'd1;

  assign prog.dcm_prog_done = done_q;
  assign multiplier         = mul_q;
  assign divider            = div_q;
  assign load_strobe        = strobe_q;
  assign frame_error        = ferr_q;
  assign error_count        = errcnt_q;

  // Next-state logic: settle countdown, frame capture and end-of-frame decode.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    pend_mul_d = pend_mul_q;
    pend_div_d = pend_div_q;
    mul_d      = mul_q;
    div_d      = div_q;
    settle_d   = settle_q;
    done_d     = done_q;
    strobe_d   = 1'b0;
    ferr_d     = 1'b0;
    errcnt_d   = errcnt_q;

    // Settle countdown; done rises on the edge the counter reaches zero.
    if (settle_q != 8'd0) begin
      settle_d = settle_q - 8'd1;
      if (settle_q == 8'd1) begin
        done_d = 1'b1;
      end else begin
        done_d = done_q;
      end
    end else begin
      settle_d = settle_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (prog.dcm_prog_en) begin
          state_d    = ST_CAPTURE;
          shift_d    = {9'd0, prog.dcm_prog_data};
          bit_cnt_d  = 4'd1;
        end else begin
          state_d    = ST_IDLE;
        end
      end

      ST_CAPTURE: begin
        if (prog.dcm_prog_en) begin
          for (int i = 0; i < 10; i++) begin
            if (bit_cnt_q == 4'(i)) begin
              shift_d[i] = prog.dcm_prog_data;
            end else begin
              shift_d[i] = shift_q[i];
            end
          end
          if (bit_cnt_q < 4'd11) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else begin
            bit_cnt_d = bit_cnt_q;
          end
        end else begin
          // Frame ended on this edge: decode and apply.
          state_d   = ST_IDLE;
          bit_cnt_d = 4'd0;
          shift_d   = 10'd0;
          if (!done_q) begin
            ferr_d = 1'b1;
          end else if ((bit_cnt_q == 4'd10) && shift_q[0]) begin
            if (!shift_q[1]) begin
              pend_div_d = field_s;
            end else if ((m_plus_s >= 9'd2) && (m_plus_s <= MAX_MUL_C)) begin
              pend_mul_d = field_s;
            end else begin
              ferr_d = 1'b1;
            end
          end else if ((bit_cnt_q == 4'd1) && !shift_q[0]) begin
            mul_d    = pend_mul_q + 8'd1;
            div_d    = pend_div_q + 8'd1;
            strobe_d = 1'b1;
            done_d   = 1'b0;
            settle_d = LATENCY_C;
          end else begin
            ferr_d = 1'b1;
          end
          if (ferr_d && (errcnt_q != 8'd255)) begin
            errcnt_d = errcnt_q + 8'd1;
          end else begin
            errcnt_d = errcnt_q;
          end
        end
      end

      default: begin
        state_d   = ST_IDLE;
        bit_cnt_d = 4'd0;
        shift_d   = 10'd0;
      end
    endcase
  end

  // State registers with synchronous reset to the initial programming.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 10'd0;
      pend_mul_q <= INIT_PMUL_C;
      pend_div_q <= INIT_PDIV_C;
      mul_q      <= INIT_MUL_C;
      div_q      <= INIT_DIV_C;
      settle_q   <= 8'd0;
      done_q     <= 1'b1;
      strobe_q   <= 1'b0;
      ferr_q     <= 1'b0;
      errcnt_q   <= 8'd0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      pend_mul_q <= pend_mul_d;
      pend_div_q <= pend_div_d;
      mul_q      <= mul_d;
      div_q      <= div_d;
      settle_q   <= settle_d;
      done_q     <= done_d;
      strobe_q   <= strobe_d;
      ferr_q     <= ferr_d;
      errcnt_q   <= errcnt_d;
    end
  end

endmodule

// File: tb/tb_dcm_prog_responder.sv
// Directed self-checking bench for dcm_prog_responder (default parameters).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_dcm_prog_responder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] multiplier, divider, error_count;
  logic       load_strobe, frame_error;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  int         c0;

  dcm_prog_responder_if ifc ();

  dcm_prog_responder dut (
    .clk         (clk),
    .reset       (reset),
    .prog        (ifc),
    .multiplier  (multiplier),
    .divider     (divider),
    .load_strobe (load_strobe),
    .frame_error (frame_error),
    .error_count (error_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Send len bits (bits[0] first), then drop en; returns after the end edge.
  task automatic send_frame(input logic [15:0] bits, input int len);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      ifc.dcm_prog_en   = 1'b1;
      ifc.dcm_prog_data = bits[i];
    end
    @(negedge clk);
    ifc.dcm_prog_en   = 1'b0;
    ifc.dcm_prog_data = 1'b0;
    @(negedge clk);
  endtask

  task automatic load_d(input logic [7:0] f);
    send_frame({6'd0, f, 2'b01}, 10);
  endtask

  task automatic load_m(input logic [7:0] f);
    send_frame({6'd0, f, 2'b11}, 10);
  endtask

  task automatic go();
    send_frame(16'd0, 1);
  endtask

  // Wait (bounded) for done to return high and check the low duration.
  task automatic wait_done(input string tag, input int start);
    int k = 0;
    while (ifc.dcm_prog_done !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check_val(tag, cyc - start, 16);
  endtask

  initial begin
    ifc.dcm_prog_en   = 1'b0;
    ifc.dcm_prog_data = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_done", ifc.dcm_prog_done, 1);
    check_val("rst_mul", multiplier, 60);
    check_val("rst_div", divider, 8);
    check_val("rst_strobe", load_strobe, 0);
    check_val("rst_ferr", frame_error, 0);
    check_val("rst_errcnt", error_count, 0);
    reset = 1'b0;
    @(negedge clk);

    // M = 100 above maximum -> rejected; GO re-applies reset values.
    load_m(8'd99);
    check_val("m100_ferr", frame_error, 1);
    check_val("m100_errcnt", error_count, 1);
    go();
    c0 = cyc;
    check_val("go0_strobe", load_strobe, 1);
    check_val("go0_mul", multiplier, 60);
    check_val("go0_div", divider, 8);
    wait_done("go0_settle", c0);

    // LoadD 7, LoadM 71, GO -> D=8, M=72, done low 16 cycles.
    load_d(8'd7);
    check_val("ld7_ferr", frame_error, 0);
    load_m(8'd71);
    check_val("lm71_ferr", frame_error, 0);
    go();
    c0 = cyc;
    check_val("go1_strobe", load_strobe, 1);
    check_val("go1_ferr", frame_error, 0);
    check_val("go1_mul", multiplier, 72);
    check_val("go1_div", divider, 8);
    check_val("go1_done", ifc.dcm_prog_done, 0);
    @(negedge clk);
    check_val("go1_strobe_pulse", load_strobe, 0);
    wait_done("go1_settle", c0);

    // M bounds: 1 rejected, 88 accepted.
    load_m(8'd0);
    check_val("m1_ferr", frame_error, 1);
    check_val("m1_errcnt", error_count, 2);
    load_m(8'd87);
    check_val("m88_ferr", frame_error, 0);
    go();
    c0 = cyc;
    check_val("go2_mul", multiplier, 88);
    wait_done("go2_settle", c0);

    // Malformed frames: 9 bits, 11 bits (LoadD 255 shape), single 1.
    send_frame({6'd0, 8'h05, 2'b01}, 9);
    check_val("len9_ferr", frame_error, 1);
    send_frame({5'd0, 1'b0, 8'hFF, 2'b01}, 11);
    check_val("len11_ferr", frame_error, 1);
    send_frame(16'h0001, 1);
    check_val("one_ferr", frame_error, 1);
    check_val("bad3_errcnt", error_count, 5);
    check_val("bad3_mul", multiplier, 88);
    check_val("bad3_div", divider, 8);

    // GO re-applies unchanged pending values; second GO 5 cycles later rejected.
    go();
    c0 = cyc;
    check_val("go3_strobe", load_strobe, 1);
    check_val("go3_div", divider, 8);
    repeat (3) @(negedge clk);
    go();
    check_val("go_busy_ferr", frame_error, 1);
    check_val("go_busy_strobe", load_strobe, 0);
    check_val("go_busy_errcnt", error_count, 6);
    check_val("go_busy_done", ifc.dcm_prog_done, 0);
    wait_done("go3_settle", c0);

    // D field 255 -> divider truncates to 0.
    load_d(8'd255);
    go();
    c0 = cyc;
    check_val("d256_div", divider, 0);
    check_val("d256_mul", multiplier, 88);
    wait_done("d256_settle", c0);

    // 300 bad frames saturate the counter.
    for (int i = 0; i < 300; i++) begin
      send_frame(16'h0001, 1);
    end
    check_val("sat_errcnt", error_count, 255);
    check_val("sat_ferr", frame_error, 1);

    // Reset after 4 bits of a LoadM discards the partial frame.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ifc.dcm_prog_en   = 1'b1;
      ifc.dcm_prog_data = 1'b1;
    end
    @(negedge clk);
    ifc.dcm_prog_en = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_val("rst2_errcnt", error_count, 0);
    check_val("rst2_ferr", frame_error, 0);
    check_val("rst2_mul", multiplier, 60);
    load_m(8'd49);
    check_val("lm49_ferr", frame_error, 0);
    go();
    check_val("go4_strobe", load_strobe, 1);
    check_val("go4_mul", multiplier, 50);
    check_val("go4_div", divider, 8);
    check_val("go4_done", ifc.dcm_prog_done, 0);

    // Reset during settle forces done high on the next edge.
    reset = 1'b1;
    @(negedge clk);
    check_val("rst_settle_done", ifc.dcm_prog_done, 1);
    check_val("rst_settle_mul", multiplier, 60);
    reset = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
